// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Requester-side bus of the shared memory-port arbiter.
//   req_valid/req_write/req_lock : per-requester request flags
//   req_addr/req_wdata           : flat packed per-requester address / data
//   req_ready                    : one-hot grant back to the requesters
//   resp_valid/resp_data         : one-hot read-data strobe and read data
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int data_depth = 5,
  parameter int data_width = 5
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*data_depth-1:0] req_addr;
  logic [NUM_REQ*data_width-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic signed [data_width-1:0]  resp_data;

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port RAM between NUM_REQ requesters. At most one request
// is granted per cycle in round-robin order; a requester may lock the port
// for back-to-back accesses. Read data returns one cycle later with a
// one-hot strobe identifying the requester.
// Ports:
//   clk, rst_n        : clock (shared with the RAM), async active-low reset
//   bus (slave)       : requester handshake, see mem_port_arbiter_if
//   mem_read/mem_write/mem_addr/mem_dataWrite : RAM control/data pins
//   mem_dataRead      : registered RAM read data (valid the cycle after read)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int data_depth = 5,
  parameter int data_width = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mem_port_arbiter_if.slave            bus,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [data_depth-1:0]        mem_addr,
  output logic [data_width-1:0]        mem_dataWrite,
  input  logic signed [data_width-1:0] mem_dataRead
);

  localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] lock_owner_q;
  logic [PTR_W-1:0] pend_tag_q;
  logic             resp_pend_q;

  logic             grant_found;
  logic             grant_vld;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   cand;

  // Unpack the flat address / data buses into per-requester words.
  logic [data_depth-1:0] addr_arr  [NUM_REQ];
  logic [data_width-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[gi*data_depth +: data_depth];
      assign wdata_arr[gi] = bus.req_wdata[gi*data_width +: data_width];
    end
  endgenerate

  // Grant selection. In ARB the scan starts at rr_ptr and wraps; the
  // candidate is one bit wider so rr_ptr+k can be folded back below NUM_REQ
  // without overflowing. In LOCKED only the owner can win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state_q == ST_LOCKED) begin
      grant_found = bus.req_valid[lock_owner_q];
      grant_idx   = lock_owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (cand >= NUM_REQ_X) begin
          cand = cand - NUM_REQ_X;
        end
        if (!grant_found && bus.req_valid[cand[PTR_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[PTR_W-1:0];
        end
      end
    end
  end

  // Nothing may reach the RAM while reset is held, even with requests pending.
  assign grant_vld = grant_found & rst_n;

  assign rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

  assign mem_write     = grant_vld &  bus.req_write[grant_idx];
  assign mem_read      = grant_vld & ~bus.req_write[grant_idx];
  assign mem_addr      = grant_vld ? addr_arr[grant_idx]  : '0;
  assign mem_dataWrite = grant_vld ? wdata_arr[grant_idx] : '0;

  // RAM output is already registered, so read data passes straight through.
  assign bus.resp_data = mem_dataRead;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign bus.req_ready[gi]  = grant_vld   && (grant_idx  == PTR_W'(gi));
      assign bus.resp_valid[gi] = resp_pend_q && (pend_tag_q == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      pend_tag_q   <= '0;
      resp_pend_q  <= 1'b0;
    end else begin
      resp_pend_q <= mem_read;
      if (mem_read) begin
        pend_tag_q <= grant_idx;
      end
      if (grant_vld) begin
        case (state_q)
          ST_ARB: begin
            rr_ptr_q <= rr_ptr_d;
            if (bus.req_lock[grant_idx]) begin
              state_q      <= ST_LOCKED;
              lock_owner_q <= grant_idx;
            end
          end
          ST_LOCKED: begin
            // rr_ptr is frozen while locked so arbitration resumes where it
            // left off once the owner releases.
            if (!bus.req_lock[grant_idx]) begin
              state_q <= ST_ARB;
            end
          end
          default: state_q <= ST_ARB;
        endcase
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memoryRAM instance between NUM_REQ requesters (PEs or load/store units of a CGRA column).
- Each cycle it grants at most one request in round-robin order and drives the RAM read/write/addr/dataWrite pins.
- It returns read data to the originating requester with a one-hot response strobe.
- An optional lock lets one requester hold the port for back-to-back accesses, such as a read-modify-write.

Parameters:
- NUM_REQ, 4, number of requesters, 2..16.
- data_depth, 5, address width; must equal the attached RAM's data_depth.
- data_width, 5, data width; must equal the attached RAM's data_width.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_lock  in  NUM_REQ  hold the grant after this access.
- req_addr  in  NUM_REQ*data_depth  flat packed addresses; requester i occupies bits [i*data_depth +: data_depth].
- req_wdata  in  NUM_REQ*data_width  flat packed write data, same packing.
- req_ready  out  NUM_REQ  one-hot grant; the transfer happens on valid&ready.
- resp_valid  out  NUM_REQ  one-hot read-data strobe.
- resp_data  out  data_width  read data, signed.
- mem_read  out  1  to RAM read.
- mem_write  out  1  to RAM write.
- mem_addr  out  data_depth  to RAM addr.
- mem_dataWrite  out  data_width  to RAM dataWrite.
- mem_dataRead  in  data_width  from RAM dataRead; the RAM registers it, so it is valid the cycle after mem_read.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rr_ptr=0, state=ARB, lock_owner=0, pend_tag=0, resp_valid=0.
  - req_ready, mem_read and mem_write are forced 0 while rst_n is low.
  - A read issued in the cycle before reset asserts produces no response.
- Grant logic is combinational from state, rr_ptr and req_valid:
  - ARB: grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - LOCKED: only lock_owner may be granted, and only when req_valid[lock_owner]=1. All other requesters see ready=0.
  - req_ready = one-hot of the grant, or 0 when there is no grant.
- RAM drive:
  - With a grant g: mem_read=~req_write[g], mem_write=req_write[g], mem_addr=req_addr[g], mem_dataWrite=req_wdata[g].
  - With no grant: mem_read=mem_write=0 and mem_addr/mem_dataWrite hold 0.
- rr_ptr update: on a grant to g, rr_ptr<=(g+1) mod NUM_REQ. With no grant it is unchanged. It is also unchanged while LOCKED.
- State machine (2 states):
  - ARB->LOCKED on a grant to g with req_lock[g]=1; lock_owner<=g.
  - LOCKED->LOCKED on a granted access with req_lock[owner]=1, or on an idle cycle (owner valid=0).
  - LOCKED->ARB on a granted access with req_lock[owner]=0. That final access completes normally; arbitration resumes the next cycle.
  - The lock is starvation-permitted by design; the software scheduler bounds lock length.
- Read response:
  - On a granted read in cycle N: pend_tag<=g and resp_valid<=onehot(g) at the cycle N+1 edge.
  - resp_data = mem_dataRead (combinational pass-through), valid while resp_valid is nonzero.
  - resp_valid is 0 in every other cycle, including after writes and idle cycles.
  - Latency is 1 cycle; throughput is 1 access/cycle; there is no response backpressure.
- Ordering:
  - A write at cycle N followed by a read of the same address at N+1 returns the new data.
  - A write and a read can never occur in the same cycle.
- No arithmetic beyond mod-NUM_REQ pointer increment; rr_ptr width is clog2(NUM_REQ).

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, mem_read=mem_write=0, resp_valid=0. Release -> requester 0 is granted first.
- Round-robin: NUM_REQ=4, all requesters issue continuous reads of addresses 1,2,3,4 -> grants rotate 0,1,2,3,0. Each resp_valid is one-hot one cycle after its grant. resp_data equals the init-file contents of that requester's address.
- Write-then-read: req 2 writes addr 7 data -3 (5'b11101) at cycle N; req 1 reads addr 7 at N+1 -> resp_valid=4'b0010 at N+2, resp_data=-3.
- Lock: req 3 asserts lock with reads at addresses 5 and 6 while reqs 0-2 stay valid -> req 3 is granted 2 consecutive cycles, then drops lock on the second access. The next grant goes to 0, since rr_ptr is unchanged from before the lock.
- Idle gaps: a single requester 1 issues a read every other cycle -> rr_ptr advances only on grants; resp_valid=0 on the intervening cycles; mem_read=0 when idle.
- Mid-operation reset: assert rst_n low one cycle after a granted read -> resp_valid stays 0. After release, state is ARB and rr_ptr=0.
